// File: rtl/riscv_seq_pkg.sv
// Shared types and constants for the shader-core instruction sequencer.
// The sequencer state encoding and the default fetch address live here.
package riscv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        FPU,
        WRITEBACK,
        HALT
    } seq_state_t;

    localparam int unsigned SEQ_DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/riscv_perf_counter.sv
// 32-bit free-running event counter with enable and synchronous clear.
// Wraps silently modulo 2^32.
module riscv_perf_counter (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    output logic [31:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/riscv_insn_sequencer.sv
// Multicycle fetch/decode/execute/writeback control FSM for one shader core.
// Performance counters are built only when RISCV_SEQ_PERF_COUNT_EN is defined.
module riscv_insn_sequencer
    import riscv_seq_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 24,
    parameter int                       INSN_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(SEQ_DEFAULT_RESET_PC)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    output logic                     halted,
    output logic                     fault,
    output logic [ADDRESS_WIDTH-1:0] pc,
    output logic                     insn_req,
    input  logic                     insn_ready,
    input  logic [INSN_WIDTH-1:0]    insn_data,
    output logic [INSN_WIDTH-1:0]    insn,
    input  logic                     is_load,
    input  logic                     is_store,
    input  logic                     is_system,
    input  logic                     is_fp_multi,
    input  logic                     writes_rd,
    output logic                     mem_req,
    input  logic                     mem_ready,
    output logic                     fpu_start,
    input  logic                     fpu_done,
    input  logic [ADDRESS_WIDTH-1:0] pc_next,
    output logic                     rd_write,
    output logic [31:0]              retired_count,
    output logic [31:0]              cycle_count
);

    seq_state_t state;
    seq_state_t state_next;

    logic fault_q;
    logic fpu_first;
    logic writes_rd_q;
    logic is_store_q;
    logic misaligned;

    assign misaligned = (pc_next[1:0] != 2'b00);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        halted     = 1'b0;
        insn_req   = 1'b0;
        mem_req    = 1'b0;
        fpu_start  = 1'b0;
        rd_write   = 1'b0;
        case (state)
            IDLE: begin
                if (run) state_next = FETCH;
            end
            FETCH: begin
                insn_req = 1'b1;
                if (insn_ready) state_next = DECODE;
            end
            DECODE: begin
                state_next = EXECUTE;
            end
            EXECUTE: begin
                if (is_system)                state_next = HALT;
                else if (is_load || is_store) state_next = MEM;
                else if (is_fp_multi)         state_next = FPU;
                else                          state_next = WRITEBACK;
            end
            MEM: begin
                mem_req = 1'b1;
                if (mem_ready) state_next = WRITEBACK;
            end
            FPU: begin
                fpu_start = fpu_first;
                if (fpu_done) state_next = WRITEBACK;
            end
            WRITEBACK: begin
                // A reset landing on the writeback cycle suppresses the register write.
                rd_write   = writes_rd_q && !is_store_q && !reset;
                state_next = misaligned ? HALT : FETCH;
            end
            HALT: begin
                halted = 1'b1;
                if (!run) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            insn        <= '0;
            fault_q     <= 1'b0;
            fpu_first   <= 1'b0;
            writes_rd_q <= 1'b0;
            is_store_q  <= 1'b0;
        end else begin
            fpu_first <= (state_next == FPU) && (state != FPU);
            case (state)
                IDLE: begin
                    if (run) begin
                        pc      <= RESET_PC;
                        fault_q <= 1'b0;
                    end
                end
                FETCH: begin
                    if (insn_ready) insn <= insn_data;
                end
                EXECUTE: begin
                    writes_rd_q <= writes_rd;
                    is_store_q  <= is_store;
                end
                WRITEBACK: begin
                    pc      <= pc_next;
                    fault_q <= misaligned;
                end
                default: begin
                end
            endcase
        end
    end

    assign fault = fault_q && (state == HALT);

`ifdef RISCV_SEQ_PERF_COUNT_EN
    logic core_active;
    logic retiring;

    assign core_active = (state != IDLE) && (state != HALT);
    assign retiring    = (state == WRITEBACK);

    riscv_perf_counter u_retired_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (retiring),
        .clear  (1'b0),
        .count  (retired_count)
    );

    riscv_perf_counter u_cycle_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (core_active),
        .clear  (1'b0),
        .count  (cycle_count)
    );
`else
    assign retired_count = '0;
    assign cycle_count   = '0;
`endif

endmodule

// File: tb/tb_riscv_insn_sequencer.sv
// Self-checking bench for riscv_insn_sequencer: directed vector table,
// hand-written reset/restart sequences and randomized instruction streams.
module tb_riscv_insn_sequencer;

    localparam int K_ALU   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;
    localparam int K_FPU   = 3;
    localparam int K_SYS   = 4;

`ifdef RISCV_SEQ_PERF_COUNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        int          kind;
        int          fw;
        int          mw;
        int          uw;
        bit          wrd;
        logic [23:0] pcn;
        int          e_lat;
        int          e_rdw;
        int          e_memc;
        int          e_fpus;
        bit          e_halt;
        bit          e_fault;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic        halted;
    logic        fault;
    logic [23:0] pc;
    logic        insn_req;
    logic        insn_ready;
    logic [31:0] insn_data;
    logic [31:0] insn;
    logic        is_load;
    logic        is_store;
    logic        is_system;
    logic        is_fp_multi;
    logic        writes_rd;
    logic        mem_req;
    logic        mem_ready;
    logic        fpu_start;
    logic        fpu_done;
    logic [23:0] pc_next;
    logic        rd_write;
    logic [31:0] retired_count;
    logic [31:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;
    int unsigned m_ret = 0;
    int unsigned m_cyc = 0;

    always #5 clock = ~clock;

    riscv_insn_sequencer #(
        .ADDRESS_WIDTH (24),
        .INSN_WIDTH    (32),
        .RESET_PC      (24'h0)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .run           (run),
        .halted        (halted),
        .fault         (fault),
        .pc            (pc),
        .insn_req      (insn_req),
        .insn_ready    (insn_ready),
        .insn_data     (insn_data),
        .insn          (insn),
        .is_load       (is_load),
        .is_store      (is_store),
        .is_system     (is_system),
        .is_fp_multi   (is_fp_multi),
        .writes_rd     (writes_rd),
        .mem_req       (mem_req),
        .mem_ready     (mem_ready),
        .fpu_start     (fpu_start),
        .fpu_done      (fpu_done),
        .pc_next       (pc_next),
        .rd_write      (rd_write),
        .retired_count (retired_count),
        .cycle_count   (cycle_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    endtask

    // Reference model: expected observable behaviour of one instruction.
    function automatic vec_t expect_of(input vec_t v);
        vec_t r;
        r = v;
        r.e_lat   = (v.fw + 1) + 2;
        r.e_rdw   = 0;
        r.e_memc  = 0;
        r.e_fpus  = 0;
        r.e_halt  = 1'b0;
        r.e_fault = 1'b0;
        if (v.kind == K_SYS) begin
            r.e_halt = 1'b1;
            return r;
        end
        if (v.kind == K_LOAD || v.kind == K_STORE) begin
            r.e_lat  += v.mw + 1;
            r.e_memc  = v.mw + 1;
        end else if (v.kind == K_FPU) begin
            r.e_lat  += v.uw + 1;
            r.e_fpus  = 1;
        end
        r.e_lat += 1;
        r.e_rdw  = (v.wrd && v.kind != K_STORE) ? 1 : 0;
        if (v.pcn[1:0] != 2'b00) begin
            r.e_halt  = 1'b1;
            r.e_fault = 1'b1;
        end
        return r;
    endfunction

    // Plays fetch/memory/FPU responder from the first FETCH cycle until the
    // next FETCH or HALT; called and returning at a negedge.
    task automatic run_insn(input vec_t v, output int lat, output int rdw, output int memc,
                            output int fpus, output bit ok, output logic [31:0] last_data);
        int fk = 0;
        int mk = 0;
        int uk = 0;
        bit fetched = 1'b0;
        bit in_fpu  = 1'b0;
        lat = 0; rdw = 0; memc = 0; fpus = 0; ok = 1'b0; last_data = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            insn_ready = 1'b0;
            mem_ready  = 1'b0;
            fpu_done   = 1'b0;
            if (fetched && (insn_req || halted)) begin
                ok = 1'b1;
                return;
            end
            lat++;
            if (insn_req) begin
                insn_data  = $urandom;
                insn_ready = (fk == v.fw);
                if (fk == v.fw) begin
                    fetched   = 1'b1;
                    last_data = insn_data;
                end
                fk++;
            end
            if (mem_req) begin
                memc++;
                mem_ready = (mk == v.mw);
                mk++;
            end
            if (fpu_start) begin
                fpus++;
                in_fpu = 1'b1;
                uk = 0;
            end
            if (in_fpu) begin
                fpu_done = (uk == v.uw);
                if (uk == v.uw) in_fpu = 1'b0;
                uk++;
            end
            if (rd_write) rdw++;
            @(negedge clock);
        end
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int lat, rdw, memc, fpus;
        bit ok;
        logic [31:0] last_data;
        logic [23:0] pc_before;
        pc_before   = pc;
        is_system   = (v.kind == K_SYS);
        is_load     = (v.kind == K_LOAD) || (v.kind == K_SYS);
        is_store    = (v.kind == K_STORE);
        is_fp_multi = (v.kind == K_FPU) || (v.kind == K_LOAD) || (v.kind == K_SYS);
        writes_rd   = v.wrd;
        pc_next     = v.pcn;
        run_insn(v, lat, rdw, memc, fpus, ok, last_data);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: instruction did not complete within 300 cycles", tag);
            finish_tb();
        end
        chk({tag, "_latency"}, 64'(lat), 64'(v.e_lat));
        chk({tag, "_rd_write"}, 64'(rdw), 64'(v.e_rdw));
        chk({tag, "_mem_req_cycles"}, 64'(memc), 64'(v.e_memc));
        chk({tag, "_fpu_start_pulses"}, 64'(fpus), 64'(v.e_fpus));
        chk({tag, "_halted"}, 64'(halted), 64'(v.e_halt));
        chk({tag, "_fault"}, 64'(fault), 64'(v.e_fault));
        chk({tag, "_pc"}, 64'(pc), 64'((v.kind == K_SYS) ? pc_before : v.pcn));
        chk({tag, "_insn"}, 64'(insn), 64'(last_data));
        m_cyc += v.e_lat;
        if (v.kind != K_SYS) m_ret++;
        chk({tag, "_retired"}, 64'(retired_count), 64'(PERF ? m_ret : 0));
        chk({tag, "_cycles"}, 64'(cycle_count), 64'(PERF ? m_cyc : 0));
    endtask

    task automatic restart();
        repeat (2) @(negedge clock);
        chk("halt_hold_with_run", 64'(halted), 64'd1);
        run = 1'b0;
        @(negedge clock);
        chk("halt_to_idle_halted", 64'(halted), 64'd0);
        chk("halt_to_idle_req", 64'(insn_req), 64'd0);
        run = 1'b1;
        @(negedge clock);
        chk("restart_fetch", 64'(insn_req), 64'd1);
        chk("restart_pc", 64'(pc), 64'd0);
        chk("restart_fault", 64'(fault), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vec_t v;
        // kind, fw, mw, uw, wrd, pcn, lat, rdw, memc, fpus, halt, fault
        vecs[0] = '{K_ALU,   0, 0,  0, 1'b1, 24'h000004,  4, 1, 0, 0, 1'b0, 1'b0};
        vecs[1] = '{K_LOAD,  1, 3,  0, 1'b1, 24'h000020,  9, 1, 4, 0, 1'b0, 1'b0};
        vecs[2] = '{K_STORE, 0, 0,  0, 1'b1, 24'h000040,  5, 0, 1, 0, 1'b0, 1'b0};
        vecs[3] = '{K_FPU,   0, 0, 10, 1'b1, 24'h000044, 15, 1, 0, 1, 1'b0, 1'b0};
        vecs[4] = '{K_FPU,   0, 0,  0, 1'b0, 24'h000048,  5, 0, 0, 1, 1'b0, 1'b0};
        vecs[5] = '{K_SYS,   0, 0,  0, 1'b1, 24'h000099,  3, 0, 0, 0, 1'b1, 1'b0};
        vecs[6] = '{K_ALU,   2, 0,  0, 1'b1, 24'h000006,  6, 1, 0, 0, 1'b1, 1'b1};
        vecs[7] = '{K_ALU,   0, 0,  0, 1'b0, 24'h000100,  4, 0, 0, 0, 1'b0, 1'b0};

        reset = 1'b1; run = 1'b0; insn_ready = 1'b0; insn_data = '0;
        is_load = 1'b0; is_store = 1'b0; is_system = 1'b0; is_fp_multi = 1'b0;
        writes_rd = 1'b0; mem_ready = 1'b0; fpu_done = 1'b0; pc_next = '0;
        repeat (3) @(negedge clock);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_insn_req", 64'(insn_req), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_fpu_start", 64'(fpu_start), 64'd0);
        chk("rst_rd_write", 64'(rd_write), 64'd0);
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_insn", 64'(insn), 64'd0);
        chk("rst_retired", 64'(retired_count), 64'd0);
        chk("rst_cycles", 64'(cycle_count), 64'd0);

        reset = 1'b0;
        @(negedge clock);
        chk("idle_without_run", 64'(insn_req), 64'd0);
        run = 1'b1;
        @(negedge clock);
        chk("start_fetch", 64'(insn_req), 64'd1);

        for (int i = 0; i < 8; i++) begin
            if (halted) restart();
            apply_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a load waits in MEM.
        is_load = 1'b1; is_store = 1'b0; is_system = 1'b0; is_fp_multi = 1'b0;
        writes_rd = 1'b1; pc_next = 24'h000080;
        for (int c = 0; c < 40; c++) begin
            insn_ready = insn_req;
            if (mem_req) break;
            @(negedge clock);
        end
        insn_ready = 1'b0;
        chk("midrst_in_mem", 64'(mem_req), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midrst_mem_req", 64'(mem_req), 64'd0);
        chk("midrst_insn_req", 64'(insn_req), 64'd0);
        chk("midrst_rd_write", 64'(rd_write), 64'd0);
        chk("midrst_pc", 64'(pc), 64'd0);
        chk("midrst_retired", 64'(retired_count), 64'd0);
        m_ret = 0;
        m_cyc = 0;
        @(negedge clock);
        chk("midrst_refetch", 64'(insn_req), 64'd1);

        for (int i = 0; i < 40; i++) begin
            if (halted) restart();
            v.kind = int'($urandom_range(0, 15));
            v.kind = (v.kind >= 14) ? K_SYS : (v.kind % 4);
            v.fw   = int'($urandom_range(0, 3));
            v.mw   = int'($urandom_range(0, 4));
            v.uw   = int'($urandom_range(0, 6));
            v.wrd  = 1'($urandom_range(0, 1));
            v.pcn  = 24'($urandom) & 24'hFFFFFC;
            if ($urandom_range(0, 7) == 0) v.pcn = v.pcn | 24'($urandom_range(1, 3));
            v = expect_of(v);
            apply_vec(v, $sformatf("rnd%0d", i));
        end

        finish_tb();
    end

endmodule
